// File: rtl/mips_pkg.sv
// mips_pkg: shared widths, reset PC and the {instr, pc} entry carried through fetch.
package mips_pkg;
    localparam int INSTR_W = 32;
    localparam int PC_W = 32;
    localparam logic [PC_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: DEPTH-entry FIFO of fetched {instr, pc}; flush empties it, head reads zero when empty.
module fetch_queue
    import mips_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  fetch_entry_t             push_entry,
    output fetch_entry_t             head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    fetch_entry_t  mem_q [DEPTH];
    logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    // Flush takes priority over any pop/push in the same cycle.
    always_comb begin
        rd_d  = flush ? '0 : rd_q + PW'(pop);
        wr_d  = flush ? '0 : wr_q + PW'(push);
        cnt_d = flush ? '0 : cnt_q + CW'(push) - CW'(pop);
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            mem_q <= '{default: '0};
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push && !flush) mem_q[wr_q] <= push_entry;
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end
    assign empty = cnt_q == '0;
    assign count = cnt_q;
    assign head  = empty ? '0 : mem_q[rd_q];
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC register driving a combinational imem, feeding a prefetch queue
// that decode drains over valid/ready; redirect flushes and restarts fetch.
module fetch_unit
    import mips_pkg::*;
#(
    parameter int                DEPTH    = 2,
    parameter int                AWIDTH   = 6,
    parameter logic [PC_W-1:0]   RESET_PC = RESET_PC_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    output logic [AWIDTH-1:0]  imem_a,
    input  logic [INSTR_W-1:0] imem_rd,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic [INSTR_W-1:0] instr,
    output logic [PC_W-1:0]    instr_pc,
    output logic               instr_valid,
    input  logic               instr_ready
);
    localparam int CW = $clog2(DEPTH) + 1;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [CW-1:0]   count;
    logic            empty, pop, push;
    fetch_entry_t    head;
    assign pop  = instr_valid & instr_ready;
    // A full queue can still accept when the head leaves the same cycle.
    assign push = !redirect & ((count < CW'(DEPTH)) | pop);
    always_comb begin
        pc_d = redirect ? (redirect_pc & ~32'h3) : push ? pc_q + 32'd4 : pc_q;
    end
    always_ff @(posedge clk) begin
        if (!reset) pc_q <= RESET_PC;
        else        pc_q <= pc_d;
    end
    fetch_queue #(.DEPTH(DEPTH)) u_queue (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .pop        (pop),
        .flush      (redirect),
        .push_entry ('{instr: imem_rd, pc: pc_q}),
        .head       (head),
        .count      (count),
        .empty      (empty)
    );
    assign imem_a      = pc_q[AWIDTH+1:2];
    assign instr       = head.instr;
    assign instr_pc    = head.pc;
    assign instr_valid = !empty;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios plus randomized traffic checked against a queue-based model.
module tb_fetch_unit;
    import mips_pkg::*;
    localparam int DEPTH = 2;
    localparam int AWIDTH = 6;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 0;
    logic        reset = 0;
    logic [5:0]  imem_a;
    logic [31:0] imem_rd;
    logic        redirect = 0;
    logic [31:0] redirect_pc = 0;
    logic [31:0] instr, instr_pc;
    logic        instr_valid;
    logic        instr_ready = 0;

    logic [31:0] mem [64];
    fetch_entry_t m_q[$];
    logic [31:0] m_pc;
    int pass_cnt = 0, total_cnt = 0;

    assign imem_rd = mem[imem_a];
    always #5 clk = ~clk;

    fetch_unit #(.DEPTH(DEPTH), .AWIDTH(AWIDTH), .RESET_PC(RST_PC)) dut (
        .clk(clk), .reset(reset), .imem_a(imem_a), .imem_rd(imem_rd),
        .redirect(redirect), .redirect_pc(redirect_pc), .instr(instr),
        .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready)
    );

    // Reference model advances on each rising edge from the inputs seen there.
    task automatic tick();
        bit v, p, pu;
        fetch_entry_t e;
        @(posedge clk);
        v  = m_q.size() != 0;
        p  = v && instr_ready;
        pu = !redirect && (m_q.size() < DEPTH || p);
        if (!reset) begin
            m_q.delete();
            m_pc = RST_PC;
        end else if (redirect) begin
            m_q.delete();
            m_pc = {redirect_pc[31:2], 2'b00};
        end else begin
            if (p) void'(m_q.pop_front());
            if (pu) begin
                e.instr = mem[(m_pc >> 2) % 64];
                e.pc = m_pc;
                m_q.push_back(e);
                m_pc = m_pc + 4;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        for (int k = 0; k < 64; k++) mem[k] = 32'h1000_0000 + k;
        reset = 0; instr_ready = 1; redirect = 0;
        tick(); tick();
        total_cnt++;
        if ({instr_valid, instr, instr_pc, imem_a} !== {1'b0, 32'h0, 32'h0, 6'd0})
            $display("FAIL reset: valid=%0b instr=%h pc=%h a=%0d, want 0/0/0/0", instr_valid, instr, instr_pc, imem_a);
        else pass_cnt++;
        reset = 1;
    endtask

    task automatic test_free_run();
        for (int i = 0; i < 6; i++) begin
            tick();
            total_cnt++;
            if ({instr_valid, instr, instr_pc} !== {1'b1, 32'h1000_0000 + i, 32'(4 * i)})
                $display("FAIL free_run[%0d]: valid=%0b instr=%h pc=%h, want 1 %h %h", i, instr_valid, instr, instr_pc, 32'h1000_0000 + i, 4 * i);
            else pass_cnt++;
        end
    endtask

    task automatic test_back_pressure();
        instr_ready = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total_cnt++;
            if ({instr_valid, instr, instr_pc, imem_a} !== {1'b1, 32'h1000_0005, 32'd20, 6'd7})
                $display("FAIL back_pressure[%0d]: valid=%0b instr=%h pc=%h a=%0d, want 1 10000005 14 7", i, instr_valid, instr, instr_pc, imem_a);
            else pass_cnt++;
        end
    endtask

    task automatic test_full_pop();
        instr_ready = 1;
        for (int j = 0; j < 4; j++) begin
            tick();
            total_cnt++;
            if ({instr_valid, instr, instr_pc, imem_a} !== {1'b1, 32'h1000_0006 + j, 32'(24 + 4 * j), 6'(8 + j)})
                $display("FAIL full_pop[%0d]: valid=%0b instr=%h pc=%h a=%0d, want pc %h a %0d", j, instr_valid, instr, instr_pc, imem_a, 24 + 4 * j, 8 + j);
            else pass_cnt++;
        end
    endtask

    task automatic test_redirect();
        redirect = 1; redirect_pc = 32'h0000_0043;
        tick();
        redirect = 0;
        total_cnt++;
        if ({instr_valid, imem_a} !== {1'b0, 6'd16})
            $display("FAIL redirect_n1: valid=%0b a=%0d, want 0 16", instr_valid, imem_a);
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({instr_valid, instr, instr_pc, imem_a} !== {1'b1, 32'h1000_0010, 32'h40, 6'd17})
            $display("FAIL redirect_n2: valid=%0b instr=%h pc=%h a=%0d, want 1 10000010 40 17", instr_valid, instr, instr_pc, imem_a);
        else pass_cnt++;
    endtask

    task automatic test_wrap();
        redirect = 1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect = 0;
        total_cnt++;
        if ({instr_valid, imem_a} !== {1'b0, 6'd63})
            $display("FAIL wrap_addr: valid=%0b a=%0d, want 0 63", instr_valid, imem_a);
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({instr_valid, instr, instr_pc, imem_a} !== {1'b1, 32'h1000_003F, 32'hFFFF_FFFC, 6'd0})
            $display("FAIL wrap_top: valid=%0b instr=%h pc=%h a=%0d, want 1 1000003f fffffffc 0", instr_valid, instr, instr_pc, imem_a);
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({instr_valid, instr, instr_pc, imem_a} !== {1'b1, 32'h1000_0000, 32'h0, 6'd1})
            $display("FAIL wrap_zero: valid=%0b instr=%h pc=%h a=%0d, want 1 10000000 0 1", instr_valid, instr, instr_pc, imem_a);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        instr_ready = 0;
        tick(); tick();
        total_cnt++;
        if (m_q.size() != DEPTH || instr_valid !== 1'b1)
            $display("FAIL reset_mid_fill: valid=%0b model_count=%0d, want 1 %0d", instr_valid, m_q.size(), DEPTH);
        else pass_cnt++;
        reset = 0; redirect = 1; redirect_pc = 32'h0000_0080;
        tick();
        total_cnt++;
        if ({instr_valid, instr, instr_pc, imem_a} !== {1'b0, 32'h0, 32'h0, RST_PC[7:2]})
            $display("FAIL reset_mid: valid=%0b instr=%h pc=%h a=%0d, want 0 0 0 %0d", instr_valid, instr, instr_pc, imem_a, RST_PC[7:2]);
        else pass_cnt++;
        reset = 1; redirect = 0; instr_ready = 1;
        tick();
        total_cnt++;
        if ({instr_valid, instr, instr_pc} !== {1'b1, 32'h1000_0000, RST_PC})
            $display("FAIL reset_mid_restart: valid=%0b instr=%h pc=%h, want 1 10000000 %h", instr_valid, instr, instr_pc, RST_PC);
        else pass_cnt++;
    endtask

    task automatic test_random();
        fetch_entry_t h;
        for (int k = 0; k < 64; k++) mem[k] = $urandom;
        for (int i = 0; i < 600; i++) begin
            instr_ready = ($urandom_range(0, 9) < 7);
            redirect    = ($urandom_range(0, 19) == 0);
            redirect_pc = $urandom;
            reset       = ($urandom_range(0, 99) != 0);
            tick();
            h = (m_q.size() != 0) ? m_q[0] : '0;
            total_cnt++;
            if ({instr_valid, instr, instr_pc, imem_a} !== {m_q.size() != 0, h.instr, h.pc, m_pc[7:2]})
                $display("FAIL random[%0d]: valid=%0b instr=%h pc=%h a=%0d, want %0b %h %h %0d",
                         i, instr_valid, instr, instr_pc, imem_a, m_q.size() != 0, h.instr, h.pc, m_pc[7:2]);
            else pass_cnt++;
        end
        reset = 1; redirect = 0;
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_back_pressure();
        test_full_pop();
        test_redirect();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
